ab_seq_gen: RTL and testbench

- Upstream stimulus stage for the a/b/c delay-operator checkers.
- On each trigger `c_i` it drives a one-cycle pulse on `a_o`, then exactly GAP cycles later a one-cycle pulse on `b_o`.
- With GAP=1 its output satisfies `c |=> a ##1 b`, and it honours the `c |=> a` environment constraint whenever it is idle.
- Triggers arriving while a sequence is in flight are counted and replayed back-to-back; excess triggers are flagged.

---
 rtl/ab_seq_pkg.sv | 20 ++
 rtl/ab_seq_gen.sv | 128 ++++++++++++
 tb/tb_ab_seq_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ab_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ab_seq_pkg : shared types and constants for the a/b sequence gen   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ab_seq_pkg;

    localparam int GAP_MAX   = 15;
    localparam int PEND_W    = 4;
    localparam int GAP_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_A  = 2'd1,
        GAP_WAIT = 2'd2,
        ISSUE_B  = 2'd3
    } ab_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/ab_seq_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ab_seq_gen : per trigger, pulse a_o then b_o GAP cycles later;     |
// |              queues triggers that arrive while a sequence runs.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ab_seq_gen
    import ab_seq_pkg::*;
#(
    parameter int GAP         = 1,
    parameter int MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_i,
    input  logic              clear_i,
    output logic              a_o,
    output logic              b_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pending_o,
    output logic              overflow_o
);

    localparam logic [GAP_CNT_W-1:0] C_GAP_LOAD = GAP_CNT_W'(GAP - 1);
    localparam logic [GAP_CNT_W-1:0] C_GAP_ONE  = GAP_CNT_W'(1);
    localparam logic [PEND_W-1:0]    C_MAX_PEND = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0]    C_PEND_ONE = PEND_W'(1);

    generate
        if (GAP < 1 || GAP > GAP_MAX) begin : g_bad_gap
            $error("ab_seq_gen: GAP must be in 1..15");
        end
        if (MAX_PENDING < 1 || MAX_PENDING > (2**PEND_W) - 1) begin : g_bad_pend
            $error("ab_seq_gen: MAX_PENDING must be in 1..15");
        end
    endgenerate

    ab_seq_state_e          r_state;
    ab_seq_state_e          w_state_nxt;
    logic [GAP_CNT_W-1:0]   r_gap_cnt;
    logic [GAP_CNT_W-1:0]   w_gap_nxt;
    logic [PEND_W-1:0]      r_pending;
    logic [PEND_W-1:0]      w_pend_nxt;
    logic                   r_overflow;
    logic                   w_overflow_nxt;
    logic                   w_slot_free;
    logic                   w_launch;
    logic                   w_drop;

    // A new sequence may start from IDLE or overlap the b-phase cycle.
    assign w_slot_free = (r_state == IDLE) || (r_state == ISSUE_B);
    assign w_launch    = w_slot_free && (c_i || (r_pending != '0));
    assign w_drop      = !w_launch && c_i && (r_pending == C_MAX_PEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gap_cnt  <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_pending  <= w_pend_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            IDLE, ISSUE_B: begin
                if (w_launch) begin
                    w_state_nxt = ISSUE_A;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE_A: begin
                if (GAP == 1) begin
                    w_state_nxt = ISSUE_B;
                end else begin
                    w_gap_nxt   = C_GAP_LOAD;
                    w_state_nxt = GAP_WAIT;
                end
            end
            GAP_WAIT: begin
                w_gap_nxt = r_gap_cnt - C_GAP_ONE;
                if (r_gap_cnt == C_GAP_ONE) begin
                    w_state_nxt = ISSUE_B;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A launch with a queued entry consumes that entry and enqueues c_i in its place.
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_launch) begin
            if ((r_pending != '0) && !c_i) begin
                w_pend_nxt = r_pending - C_PEND_ONE;
            end
        end else if (c_i && !w_drop) begin
            w_pend_nxt = r_pending + C_PEND_ONE;
        end
    end

    always_comb begin
        w_overflow_nxt = r_overflow;
        if (w_drop) begin
            w_overflow_nxt = 1'b1;
        end else if (clear_i) begin
            w_overflow_nxt = 1'b0;
        end
    end

    assign a_o        = (r_state == ISSUE_A);
    assign b_o        = (r_state == ISSUE_B);
    assign busy_o     = (r_state != IDLE);
    assign pending_o  = r_pending;
    assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ab_seq_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ab_seq_gen : two ab_seq_gen configurations against a sequence-  |
// |                 level model, plus hand-computed anchor points.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ab_seq_gen;

    typedef struct {
        bit active;
        int ph;
        int pend;
        bit ovf;
    } mstate_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       c_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       a_w [2];
    logic       b_w [2];
    logic       busy_w [2];
    logic [3:0] pend_w [2];
    logic       ovf_w [2];

    int      tests = 0;
    int      fails = 0;
    int      dcyc  = -1;
    bit      dir_on = 1'b0;
    mstate_t m [2];
    event    ev_rst;

    always #5 clk = ~clk;

    ab_seq_gen #(.GAP(1), .MAX_PENDING(4)) u_dut0 (
        .clk(clk), .rst(rst), .c_i(c_i), .clear_i(clear_i),
        .a_o(a_w[0]), .b_o(b_w[0]), .busy_o(busy_w[0]),
        .pending_o(pend_w[0]), .overflow_o(ovf_w[0])
    );

    ab_seq_gen #(.GAP(3), .MAX_PENDING(2)) u_dut1 (
        .clk(clk), .rst(rst), .c_i(c_i), .clear_i(clear_i),
        .a_o(a_w[1]), .b_o(b_w[1]), .busy_o(busy_w[1]),
        .pending_o(pend_w[1]), .overflow_o(ovf_w[1])
    );

    function automatic int gap_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int maxp_of(int k);
        return (k == 0) ? 4 : 2;
    endfunction

    // ph counts cycles since the a-pulse; b fires at ph==gap, and that
    // cycle is also a free slot for the next sequence.
    function automatic mstate_t model_step(mstate_t s, int gap, int maxp, bit c, bit clr);
        mstate_t n;
        bit      free_slot;
        bit      launch;
        n         = s;
        free_slot = !s.active || (s.ph == gap);
        launch    = free_slot && (c || (s.pend > 0));
        if (clr) n.ovf = 1'b0;
        if (launch) begin
            n.active = 1'b1;
            n.ph     = 0;
            if (s.pend > 0) n.pend = s.pend - 1 + (c ? 1 : 0);
        end else begin
            if (s.active) begin
                if (s.ph == gap) n.active = 1'b0;
                else             n.ph     = s.ph + 1;
            end
            if (c) begin
                if (s.pend < maxp) n.pend = s.pend + 1;
                else               n.ovf  = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) m[k] <= '{1'b0, 0, 0, 1'b0};
            else     m[k] <= model_step(m[k], gap_of(k), maxp_of(k), c_i, clear_i);
        end
    end

    task automatic chk(string nm, int k, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[dut%0d] t=%0t cyc=%0d: got %0d expected %0d", nm, k, $time, dcyc, act, exp);
        end
    endtask

    always begin
        @(negedge clk or ev_rst);
        for (int k = 0; k < 2; k++) begin
            chk("a_o",       k, 8'(a_w[k]),    8'(m[k].active && m[k].ph == 0));
            chk("b_o",       k, 8'(b_w[k]),    8'(m[k].active && m[k].ph == gap_of(k)));
            chk("busy_o",    k, 8'(busy_w[k]), 8'(m[k].active));
            chk("pending_o", k, 8'(pend_w[k]), 8'(m[k].pend));
            chk("overflow_o",k, 8'(ovf_w[k]),  8'(m[k].ovf));
            if (rst) begin
                chk("rst_zero", k, {3'b0, a_w[k], b_w[k], busy_w[k], ovf_w[k], |pend_w[k]}, 8'd0);
            end
        end
        if (dir_on) begin
            case (dcyc)
                0: for (int k = 0; k < 2; k++)
                       chk("init_zero", k, {3'b0, a_w[k], b_w[k], busy_w[k], ovf_w[k], |pend_w[k]}, 8'd0);
                1: begin chk("lit_a", 0, 8'(a_w[0]), 8'd1); chk("lit_a", 1, 8'(a_w[1]), 8'd1); end
                2: chk("lit_b", 0, 8'(b_w[0]), 8'd1);
                3: chk("lit_ovf", 1, 8'(ovf_w[1]), 8'd0);
                4: begin
                       chk("lit_pend", 0, 8'(pend_w[0]), 8'd2);
                       chk("lit_b",    1, 8'(b_w[1]),    8'd1);
                       chk("lit_ovf",  1, 8'(ovf_w[1]),  8'd1);
                   end
                5: begin chk("lit_a", 0, 8'(a_w[0]), 8'd1); chk("lit_pend", 1, 8'(pend_w[1]), 8'd2); end
                11: chk("lit_a", 0, 8'(a_w[0]), 8'd1);
                12: begin chk("lit_b", 0, 8'(b_w[0]), 8'd1); chk("lit_ovf", 0, 8'(ovf_w[0]), 8'd0); end
                13: begin chk("lit_busy", 0, 8'(busy_w[0]), 8'd0); chk("lit_a", 1, 8'(a_w[1]), 8'd1); end
                16: chk("lit_b", 1, 8'(b_w[1]), 8'd1);
                17: chk("lit_busy", 1, 8'(busy_w[1]), 8'd0);
                20: chk("lit_ovf", 1, 8'(ovf_w[1]), 8'd1);
                21: chk("lit_ovf", 1, 8'(ovf_w[1]), 8'd0);
                default: ;
            endcase
        end
    end

    initial begin
        int dens;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        dir_on = 1'b1;

        // Trigger burst on cycles 0..5, overflow clear on cycle 20.
        for (int t = 0; t < 25; t++) begin
            dcyc    = t;
            c_i     = (t <= 5);
            clear_i = (t == 20);
            @(posedge clk);
            #1;
        end
        dir_on  = 1'b0;
        c_i     = 1'b0;
        clear_i = 1'b0;

        // Async reset while dut1 sits in GAP_WAIT with queued triggers.
        c_i = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        c_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        -> ev_rst;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) begin @(posedge clk); #1; end

        dens = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) dens = $urandom_range(10, 95);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            c_i     = ($urandom_range(0, 99) < dens);
            clear_i = ($urandom_range(0, 99) < 3);
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        c_i     = 1'b0;
        clear_i = 1'b0;
        repeat (40) begin @(posedge clk); #1; end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
